// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings for the RV64 forwarding/hazard controller.
// Operand-mux selects, controller FSM states and the canonical NOP.
package pipe_hazard_unit_pkg;

  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_LS  = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;
  localparam logic [1:0] FW_WBQ = 2'b11;

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_unit_fwd_sel.sv
// Priority forward-select for a single EX source operand.
// LS beats WB beats the one-cycle WB_Q copy; x0 never forwards.
module fwd_sel_1src
  import pipe_hazard_unit_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] rs,
  input  logic [IDX_W-1:0] rd_ls,
  input  logic             wben_ls,
  input  logic [IDX_W-1:0] rd_wb,
  input  logic             wben_wb,
  input  logic [IDX_W-1:0] wbq_rd,
  input  logic             wbq_valid,
  output logic [1:0]       sel
);

  logic nz;
  logic hit_ls;
  logic hit_wb;
  logic hit_wbq;

  assign nz      = (rs != '0);
  assign hit_ls  = nz && wben_ls && (rd_ls == rs);
  assign hit_wb  = nz && wben_wb && (rd_wb == rs);
  assign hit_wbq = nz && wbq_valid && (wbq_rd == rs);

  always_comb begin
    sel = FW_RF;
    if (hit_ls) begin
      sel = FW_LS;
    end else if (hit_wb) begin
      sel = FW_WB;
    end else if (hit_wbq) begin
      sel = FW_WBQ;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding, load-use, redirect and freeze control for IF/ID/EX/LS/WB.
// Define HAZARD_PERF_CNT_EN to add stall/flush/freeze event counters.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NSRC  = 2,
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*IDX_W-1:0] rs_idx_id,
  input  logic [NSRC-1:0]       rs_used_id,
  input  logic [NSRC*IDX_W-1:0] rs_idx_ex,
  input  logic [IDX_W-1:0]      rd_ex,
  input  logic [IDX_W-1:0]      rd_ls,
  input  logic [IDX_W-1:0]      rd_wb,
  input  logic                  wben_ex,
  input  logic                  wben_ls,
  input  logic                  wben_wb,
  input  logic                  is_load_ex,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  redirect_ex,
  input  logic                  ls_busy,
  output logic [NSRC*2-1:0]     fw_sel,
  output logic [XLEN-1:0]       wb_data_q,
  output logic                  stall_pc,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           freeze_cnt
`endif
);

  hz_state_e        state_q;
  hz_state_e        state_d;
  logic             wbq_valid;
  logic [IDX_W-1:0] wbq_rd;
  logic [XLEN-1:0]  wbq_data;
  logic [NSRC-1:0]  lu_hit;
  logic             load_use;
  logic             stall;
  logic             bubble;
  logic             flush;

  assign freeze = ls_busy;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_sel_1src #(
      .IDX_W(IDX_W)
    ) u_fwd (
      .rs       (rs_idx_ex[k*IDX_W +: IDX_W]),
      .rd_ls    (rd_ls),
      .wben_ls  (wben_ls),
      .rd_wb    (rd_wb),
      .wben_wb  (wben_wb),
      .wbq_rd   (wbq_rd),
      .wbq_valid(wbq_valid),
      .sel      (fw_sel[k*2 +: 2])
    );

    assign lu_hit[k] = rs_used_id[k] &&
                       (rs_idx_id[k*IDX_W +: IDX_W] == rd_ex);
  end

  assign load_use = is_load_ex && wben_ex &&
                    (rd_ex != '0) && (|lu_hit);

  // Covers the regfile read-before-write slot for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbq_valid <= 1'b0;
      wbq_rd    <= '0;
      wbq_data  <= '0;
    end else if (!freeze) begin
      if (wben_wb && (rd_wb != '0)) begin
        wbq_valid <= 1'b1;
        wbq_rd    <= rd_wb;
        wbq_data  <= wb_data;
      end else begin
        wbq_valid <= 1'b0;
      end
    end
  end

  assign wb_data_q = wbq_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect wins over load-use; a frozen pipe keeps the FSM still.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (!freeze) begin
      if (redirect_ex) begin
        flush   = 1'b1;
        bubble  = 1'b1;
        state_d = RUN;
      end else if (state_q == LU) begin
        state_d = RUN;
      end else if (load_use) begin
        stall   = 1'b1;
        bubble  = 1'b1;
        state_d = LU;
      end
    end
  end

  assign stall_pc  = stall;
  assign stall_id  = stall;
  assign bubble_ex = bubble;
  assign flush_id  = flush;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
      if (freeze) begin
        freeze_cnt <= freeze_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
